// File: rtl/mips_defs_pkg.sv
// Shared MIPS decode constants: opcode/funct encodings, one-hot op bit positions,
// the reset vector and the link register index.
package mips_defs_pkg;

  localparam int OP_W = 20;
  localparam logic [31:0] RESET_PC_DEF = 32'hbfc00000;
  localparam logic [4:0]  REG_RA       = 5'd31;

  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_J       = 6'h02;
  localparam logic [5:0] OPC_JAL     = 6'h03;
  localparam logic [5:0] OPC_BEQ     = 6'h04;
  localparam logic [5:0] OPC_BNE     = 6'h05;
  localparam logic [5:0] OPC_ADDIU   = 6'h09;
  localparam logic [5:0] OPC_LUI     = 6'h0f;
  localparam logic [5:0] OPC_LW      = 6'h23;
  localparam logic [5:0] OPC_SW      = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  // One-hot positions; R-type ALU ops occupy ADDU..SRA, control flow BEQ..JR.
  localparam int OPB_ADDU  = 0;
  localparam int OPB_SUBU  = 1;
  localparam int OPB_SLT   = 2;
  localparam int OPB_SLTU  = 3;
  localparam int OPB_AND   = 4;
  localparam int OPB_OR    = 5;
  localparam int OPB_XOR   = 6;
  localparam int OPB_NOR   = 7;
  localparam int OPB_SLL   = 8;
  localparam int OPB_SRL   = 9;
  localparam int OPB_SRA   = 10;
  localparam int OPB_ADDIU = 11;
  localparam int OPB_LUI   = 12;
  localparam int OPB_LW    = 13;
  localparam int OPB_SW    = 14;
  localparam int OPB_BEQ   = 15;
  localparam int OPB_BNE   = 16;
  localparam int OPB_J     = 17;
  localparam int OPB_JAL   = 18;
  localparam int OPB_JR    = 19;

endpackage

// File: rtl/de_branch_unit.sv
// Combinational branch/jump resolver for the decode stage: taken flag and target
// address for BEQ/BNE/J/JAL/JR given the (possibly forwarded) operands.
module de_branch_unit
  import mips_defs_pkg::*;
(
  input  logic        is_beq,
  input  logic        is_bne,
  input  logic        is_j,
  input  logic        is_jal,
  input  logic        is_jr,
  input  logic [31:0] pc,
  input  logic [15:0] imm,
  input  logic [25:0] idx,
  input  logic [31:0] rs_op,
  input  logic [31:0] rt_op,
  output logic        br_taken,
  output logic [31:0] br_target
);

  logic [31:0] pc4;
  logic [31:0] br_off;

  always_comb begin
    pc4       = pc + 32'd4;
    br_off    = {{14{imm[15]}}, imm, 2'b00};
    br_taken  = 1'b0;
    br_target = pc4 + br_off;
    if (is_beq) begin
      br_taken = (rs_op == rt_op);
    end else if (is_bne) begin
      br_taken = (rs_op != rt_op);
    end else if (is_j || is_jal) begin
      br_taken  = 1'b1;
      br_target = {pc4[31:28], idx, 2'b00};
    end else if (is_jr) begin
      br_taken  = 1'b1;
      br_target = rs_op;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS decode stage: pipeline register, one-hot decode, branch resolution and
// nextpc steering. Define DE_FWD_EN to add exe/mem operand forwarding ports.
module decode_stage
  import mips_defs_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fe_valid,
  input  logic [31:0]     fe_pc,
  input  logic [31:0]     fe_inst,
  output logic [31:0]     nextpc,
  output logic            de_allowin,
  input  logic            exe_allowin,
  input  logic            stall_req,
  output logic [4:0]      de_rf_raddr1,
  output logic [4:0]      de_rf_raddr2,
  input  logic [31:0]     rs_value,
  input  logic [31:0]     rt_value,
`ifdef DE_FWD_EN
  input  logic            exe_fwd_we,
  input  logic [4:0]      exe_fwd_dest,
  input  logic [31:0]     exe_fwd_data,
  input  logic            mem_fwd_we,
  input  logic [4:0]      mem_fwd_dest,
  input  logic [31:0]     mem_fwd_data,
`endif
  output logic            de_to_exe_valid,
  output logic [31:0]     de_pc,
  output logic [31:0]     de_inst,
  output logic [OP_W-1:0] de_op,
  output logic [31:0]     de_src1,
  output logic [31:0]     de_src2,
  output logic [4:0]      de_dest,
  output logic            de_bd,
  output logic            de_ri
);

  // Handshake: valid moves downstream when de_to_exe_valid & exe_allowin;
  // upstream sees de_allowin, which drops only while a held instruction cannot leave.
  logic        de_valid_q, de_valid_d;
  logic [31:0] de_pc_q, de_pc_d;
  logic [31:0] de_inst_q, de_inst_d;
  logic        de_bd_q, de_bd_d;
  logic        prev_is_br_q, prev_is_br_d;

  logic        ready_go;
  logic        is_br;
  logic        br_adv;
  logic        bd_pend;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] rs_op, rt_op;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs_f, rt_f, rd_f;
  logic [15:0] imm;

  assign opcode = de_inst_q[31:26];
  assign funct  = de_inst_q[5:0];
  assign rs_f   = de_inst_q[25:21];
  assign rt_f   = de_inst_q[20:16];
  assign rd_f   = de_inst_q[15:11];
  assign imm    = de_inst_q[15:0];

  assign ready_go        = ~(de_valid_q & stall_req);
  assign de_allowin      = ~de_valid_q | (ready_go & exe_allowin);
  assign de_to_exe_valid = de_valid_q & ready_go;

  assign de_pc        = de_pc_q;
  assign de_inst      = de_inst_q;
  assign de_bd        = de_bd_q;
  assign de_rf_raddr1 = rs_f;
  assign de_rf_raddr2 = rt_f;

`ifdef DE_FWD_EN
  // Youngest producer wins; $zero is hardwired and never forwarded.
  always_comb begin
    rs_op = rs_value;
    if (exe_fwd_we && exe_fwd_dest != 5'd0 && exe_fwd_dest == rs_f) rs_op = exe_fwd_data;
    else if (mem_fwd_we && mem_fwd_dest != 5'd0 && mem_fwd_dest == rs_f) rs_op = mem_fwd_data;
    rt_op = rt_value;
    if (exe_fwd_we && exe_fwd_dest != 5'd0 && exe_fwd_dest == rt_f) rt_op = exe_fwd_data;
    else if (mem_fwd_we && mem_fwd_dest != 5'd0 && mem_fwd_dest == rt_f) rt_op = mem_fwd_data;
  end
`else
  assign rs_op = rs_value;
  assign rt_op = rt_value;
`endif

  always_comb begin
    de_op = '0;
    case (opcode)
      OPC_SPECIAL: begin
        case (funct)
          FN_ADDU: de_op[OPB_ADDU] = 1'b1;
          FN_SUBU: de_op[OPB_SUBU] = 1'b1;
          FN_SLT:  de_op[OPB_SLT]  = 1'b1;
          FN_SLTU: de_op[OPB_SLTU] = 1'b1;
          FN_AND:  de_op[OPB_AND]  = 1'b1;
          FN_OR:   de_op[OPB_OR]   = 1'b1;
          FN_XOR:  de_op[OPB_XOR]  = 1'b1;
          FN_NOR:  de_op[OPB_NOR]  = 1'b1;
          FN_SLL:  de_op[OPB_SLL]  = 1'b1;
          FN_SRL:  de_op[OPB_SRL]  = 1'b1;
          FN_SRA:  de_op[OPB_SRA]  = 1'b1;
          FN_JR:   de_op[OPB_JR]   = 1'b1;
          default: ;
        endcase
      end
      OPC_ADDIU: de_op[OPB_ADDIU] = 1'b1;
      OPC_LUI:   de_op[OPB_LUI]   = 1'b1;
      OPC_LW:    de_op[OPB_LW]    = 1'b1;
      OPC_SW:    de_op[OPB_SW]    = 1'b1;
      OPC_BEQ:   de_op[OPB_BEQ]   = 1'b1;
      OPC_BNE:   de_op[OPB_BNE]   = 1'b1;
      OPC_J:     de_op[OPB_J]     = 1'b1;
      OPC_JAL:   de_op[OPB_JAL]   = 1'b1;
      default: ;
    endcase
  end

  assign de_ri = ~|de_op;
  assign is_br = |de_op[OPB_JR:OPB_BEQ];

  always_comb begin
    de_src1 = rs_op;
    if (de_op[OPB_JAL]) de_src1 = de_pc_q + 32'd8;
    de_src2 = rt_op;
    if (de_op[OPB_ADDIU] | de_op[OPB_LW] | de_op[OPB_SW]) de_src2 = {{16{imm[15]}}, imm};
    else if (de_op[OPB_LUI]) de_src2 = {imm, 16'h0000};
    else if (de_op[OPB_JAL]) de_src2 = 32'd0;
    de_dest = 5'd0;
    if (|de_op[OPB_SRA:OPB_ADDU]) de_dest = rd_f;
    else if (de_op[OPB_ADDIU] | de_op[OPB_LUI] | de_op[OPB_LW]) de_dest = rt_f;
    else if (de_op[OPB_JAL]) de_dest = REG_RA;
  end

  de_branch_unit u_branch (
    .is_beq    (de_op[OPB_BEQ]),
    .is_bne    (de_op[OPB_BNE]),
    .is_j      (de_op[OPB_J]),
    .is_jal    (de_op[OPB_JAL]),
    .is_jr     (de_op[OPB_JR]),
    .pc        (de_pc_q),
    .imm       (imm),
    .idx       (de_inst_q[25:0]),
    .rs_op     (rs_op),
    .rt_op     (rt_op),
    .br_taken  (br_taken),
    .br_target (br_target)
  );

  // A branch leaving now makes whatever enters this cycle (or later) its delay slot.
  assign br_adv  = de_to_exe_valid & exe_allowin & is_br;
  assign bd_pend = prev_is_br_q | br_adv;

  always_comb begin
    de_valid_d   = de_valid_q;
    de_pc_d      = de_pc_q;
    de_inst_d    = de_inst_q;
    de_bd_d      = de_bd_q;
    prev_is_br_d = bd_pend;
    if (de_allowin) de_valid_d = fe_valid;
    if (de_allowin && fe_valid) begin
      de_pc_d      = fe_pc;
      de_inst_d    = fe_inst;
      de_bd_d      = bd_pend;
      prev_is_br_d = 1'b0;
    end
  end

  always_comb begin
    nextpc = fe_pc + 32'd4;
    if (!de_allowin) nextpc = fe_pc;
    else if (br_taken && de_to_exe_valid && exe_allowin) nextpc = br_target;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_valid_q   <= 1'b0;
      de_pc_q      <= RESET_PC;
      de_inst_q    <= 32'd0;
      de_bd_q      <= 1'b0;
      prev_is_br_q <= 1'b0;
    end else begin
      de_valid_q   <= de_valid_d;
      de_pc_q      <= de_pc_d;
      de_inst_q    <= de_inst_d;
      de_bd_q      <= de_bd_d;
      prev_is_br_q <= prev_is_br_d;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized run
// against a mnemonic-level reference model and an in-order retirement scoreboard.
module tb_decode_stage;

  localparam logic [31:0] RST_PC = 32'hbfc00000;
  localparam logic [31:0] ADDU_I = 32'h00221821; // addu $3,$1,$2

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fe_valid, exe_allowin, stall_req;
  logic [31:0] fe_pc, fe_inst, rs_value, rt_value;
  logic [31:0] nextpc, de_pc, de_inst, de_src1, de_src2;
  logic        de_allowin, de_to_exe_valid, de_bd, de_ri;
  logic [4:0]  de_rf_raddr1, de_rf_raddr2, de_dest;
  logic [19:0] de_op;
`ifdef DE_FWD_EN
  logic        exe_fwd_we = 1'b0, mem_fwd_we = 1'b0;
  logic [4:0]  exe_fwd_dest = 5'd0, mem_fwd_dest = 5'd0;
  logic [31:0] exe_fwd_data = 32'd0, mem_fwd_data = 32'd0;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // Reference model state and expected combinational outputs
  logic        m_valid, m_bd, m_pend;
  logic [31:0] m_pc, m_inst;
  logic        e_allowin, e_tev;
  logic [31:0] e_nextpc, e_src1, e_src2;
  logic [19:0] e_op;
  logic [4:0]  e_dest;
  logic        e_ri;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk             (clk),
    .reset           (reset),
    .fe_valid        (fe_valid),
    .fe_pc           (fe_pc),
    .fe_inst         (fe_inst),
    .nextpc          (nextpc),
    .de_allowin      (de_allowin),
    .exe_allowin     (exe_allowin),
    .stall_req       (stall_req),
    .de_rf_raddr1    (de_rf_raddr1),
    .de_rf_raddr2    (de_rf_raddr2),
    .rs_value        (rs_value),
    .rt_value        (rt_value),
`ifdef DE_FWD_EN
    .exe_fwd_we      (exe_fwd_we),
    .exe_fwd_dest    (exe_fwd_dest),
    .exe_fwd_data    (exe_fwd_data),
    .mem_fwd_we      (mem_fwd_we),
    .mem_fwd_dest    (mem_fwd_dest),
    .mem_fwd_data    (mem_fwd_data),
`endif
    .de_to_exe_valid (de_to_exe_valid),
    .de_pc           (de_pc),
    .de_inst         (de_inst),
    .de_op           (de_op),
    .de_src1         (de_src1),
    .de_src2         (de_src2),
    .de_dest         (de_dest),
    .de_bd           (de_bd),
    .de_ri           (de_ri)
  );

  // Mnemonic index in the one-hot order ADDU..JR, or -1 when not supported.
  function automatic int classify(input logic [31:0] inst);
    logic [5:0] opc, fn;
    opc = inst[31:26];
    fn  = inst[5:0];
    if (opc == 6'h00) begin
      case (fn)
        6'h21: return 0;  6'h23: return 1;  6'h2a: return 2;  6'h2b: return 3;
        6'h24: return 4;  6'h25: return 5;  6'h26: return 6;  6'h27: return 7;
        6'h00: return 8;  6'h02: return 9;  6'h03: return 10; 6'h08: return 19;
        default: return -1;
      endcase
    end
    case (opc)
      6'h09: return 11; 6'h0f: return 12; 6'h23: return 13; 6'h2b: return 14;
      6'h04: return 15; 6'h05: return 16; 6'h02: return 17; 6'h03: return 18;
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf);
`ifdef DE_FWD_EN
    if (exe_fwd_we && r != 0 && exe_fwd_dest == r) return exe_fwd_data;
    if (mem_fwd_we && r != 0 && mem_fwd_dest == r) return mem_fwd_data;
`endif
    return rf;
  endfunction

  function automatic logic [31:0] rand_inst(input int k);
    logic [4:0]  a, b, c;
    logic [15:0] im;
    logic [25:0] ix;
    logic [5:0]  fns[12];
    logic [5:0]  opcs[8];
    a = 5'($urandom_range(0, 3));
    b = 5'($urandom_range(0, 3));
    c = 5'($urandom_range(0, 31));
    im = 16'($urandom);
    ix = 26'($urandom);
    fns  = '{6'h21, 6'h23, 6'h2a, 6'h2b, 6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h02, 6'h03, 6'h08};
    opcs = '{6'h09, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03};
    if (k < 12) return {6'h00, a, b, c, 5'($urandom), fns[k]};
    if (k < 18) return {opcs[k-12], a, b, im};
    if (k < 20) return {opcs[k-12], ix};
    return {6'h3f, a, b, im};
  endfunction

  task automatic drive(input logic fv, input logic [31:0] pc, input logic [31:0] inst,
                       input logic ea, input logic st, input logic [31:0] rs, input logic [31:0] rt);
    fe_valid = fv; fe_pc = pc; fe_inst = inst;
    exe_allowin = ea; stall_req = st; rs_value = rs; rt_value = rt;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    drive(1'b0, RST_PC, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0);
    reset = 1'b1;
    m_valid = 1'b0; m_pc = RST_PC; m_inst = 32'd0; m_bd = 1'b0; m_pend = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic model_outputs();
    int cls;
    logic [31:0] rs, rt, pc4, target;
    logic taken;
    cls = classify(m_inst);
    rs  = operand(m_inst[25:21], rs_value);
    rt  = operand(m_inst[20:16], rt_value);
    pc4 = m_pc + 32'd4;
    e_tev     = m_valid && !stall_req;
    e_allowin = !m_valid || (!stall_req && exe_allowin);
    taken = m_valid && ((cls == 15 && rs == rt) || (cls == 16 && rs != rt) || cls >= 17);
    if (cls == 19) target = rs;
    else if (cls == 17 || cls == 18) target = {pc4[31:28], m_inst[25:0], 2'b00};
    else target = pc4 + {{14{m_inst[15]}}, m_inst[15:0], 2'b00};
    if (!e_allowin) e_nextpc = fe_pc;
    else if (taken && e_tev && exe_allowin) e_nextpc = target;
    else e_nextpc = fe_pc + 32'd4;
    e_op = (cls < 0) ? 20'd0 : (20'd1 << cls);
    e_ri = (cls < 0);
    if (cls >= 0 && cls <= 10) e_dest = m_inst[15:11];
    else if (cls >= 11 && cls <= 13) e_dest = m_inst[20:16];
    else if (cls == 18) e_dest = 5'd31;
    else e_dest = 5'd0;
    e_src1 = (cls == 18) ? m_pc + 32'd8 : rs;
    if (cls == 11 || cls == 13 || cls == 14) e_src2 = {{16{m_inst[15]}}, m_inst[15:0]};
    else if (cls == 12) e_src2 = {m_inst[15:0], 16'h0000};
    else if (cls == 18) e_src2 = 32'd0;
    else e_src2 = rt;
  endtask

  // Advances the model across one clock edge; called just before the edge.
  task automatic model_step();
    int cls;
    logic pend;
    cls  = classify(m_inst);
    pend = m_pend || (e_tev && exe_allowin && cls >= 15);
    if (e_allowin) begin
      m_valid = fe_valid;
      if (fe_valid) begin
        m_pc = fe_pc; m_inst = fe_inst; m_bd = pend; pend = 1'b0;
        exp_q.push_back(fe_pc);
      end
    end
    m_pend = pend;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (de_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin got=%b exp=1", de_allowin); end
    checks++; if (de_to_exe_valid !== 1'b0) begin errors++; $display("FAIL reset_tev got=%b exp=0", de_to_exe_valid); end
    checks++; if (de_pc !== RST_PC) begin errors++; $display("FAIL reset_pc got=%h exp=%h", de_pc, RST_PC); end
    checks++; if (de_inst !== 32'd0) begin errors++; $display("FAIL reset_inst got=%h exp=0", de_inst); end
    checks++; if (de_bd !== 1'b0) begin errors++; $display("FAIL reset_bd got=%b exp=0", de_bd); end
  endtask

  task automatic test_straight_line();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, RST_PC + 32'(4 * i), ADDU_I, 1'b1, 1'b0, 32'd1, 32'd2);
      #1;
      checks++; if (nextpc !== RST_PC + 32'(4 * i + 4)) begin errors++; $display("FAIL line_nextpc got=%h exp=%h", nextpc, RST_PC + 32'(4 * i + 4)); end
      if (i > 0) begin
        checks++; if (de_to_exe_valid !== 1'b1 || de_op !== 20'd1) begin errors++; $display("FAIL line_op got=%b/%h exp=1/00001", de_to_exe_valid, de_op); end
        checks++; if (de_pc !== RST_PC + 32'(4 * i - 4)) begin errors++; $display("FAIL line_pc got=%h exp=%h", de_pc, RST_PC + 32'(4 * i - 4)); end
        checks++; if (de_dest !== 5'd3 || de_src1 !== 32'd1 || de_src2 !== 32'd2) begin errors++; $display("FAIL line_fields got=%0d/%h/%h exp=3/1/2", de_dest, de_src1, de_src2); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch(input logic [31:0] bpc, input logic [31:0] inst, input logic [31:0] v,
                             input logic [31:0] exp_np, input string nm);
    apply_reset();
    drive(1'b1, bpc, inst, 1'b1, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    drive(1'b1, bpc + 32'd4, ADDU_I, 1'b1, 1'b0, v, v);
    #1;
    checks++; if (nextpc !== exp_np) begin errors++; $display("FAIL %s_nextpc got=%h exp=%h", nm, nextpc, exp_np); end
    checks++; if (de_to_exe_valid !== 1'b1) begin errors++; $display("FAIL %s_tev got=%b exp=1", nm, de_to_exe_valid); end
    @(negedge clk);
    drive(1'b1, exp_np, ADDU_I, 1'b1, 1'b0, v, v);
    #1;
    checks++; if (de_pc !== bpc + 32'd4 || de_bd !== 1'b1) begin errors++; $display("FAIL %s_slot got=%h/%b exp=%h/1", nm, de_pc, de_bd, bpc + 32'd4); end
    @(negedge clk);
    drive(1'b0, exp_np + 32'd4, ADDU_I, 1'b1, 1'b0, v, v);
    #1;
    checks++; if (de_pc !== exp_np || de_bd !== 1'b0) begin errors++; $display("FAIL %s_after got=%h/%b exp=%h/0", nm, de_pc, de_bd, exp_np); end
  endtask

  task automatic test_stall_jr();
    apply_reset();
    drive(1'b1, 32'hbfc00040, 32'h00800008, 1'b1, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    drive(1'b1, 32'hbfc00044, ADDU_I, 1'b1, 1'b1, 32'h80001000, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (de_allowin !== 1'b0 || de_to_exe_valid !== 1'b0) begin errors++; $display("FAIL stall_hs got=%b/%b exp=0/0", de_allowin, de_to_exe_valid); end
      checks++; if (nextpc !== 32'hbfc00044) begin errors++; $display("FAIL stall_nextpc got=%h exp=bfc00044", nextpc); end
      @(negedge clk);
    end
    stall_req = 1'b0;
    #1;
    checks++; if (nextpc !== 32'h80001000) begin errors++; $display("FAIL jr_target got=%h exp=80001000", nextpc); end
    @(negedge clk);
    drive(1'b0, 32'h80001000, ADDU_I, 1'b1, 1'b0, 32'd0, 32'd0);
    #1;
    checks++; if (de_pc !== 32'hbfc00044 || de_bd !== 1'b1) begin errors++; $display("FAIL jr_slot got=%h/%b exp=bfc00044/1", de_pc, de_bd); end
  endtask

  task automatic test_backpressure_reset();
    apply_reset();
    drive(1'b1, 32'hbfc00050, ADDU_I, 1'b1, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    drive(1'b1, 32'hbfc00054, 32'h24010005, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (de_pc !== 32'hbfc00050 || de_inst !== ADDU_I) begin errors++; $display("FAIL bp_hold got=%h/%h exp=bfc00050/%h", de_pc, de_inst, ADDU_I); end
      checks++; if (de_allowin !== 1'b0 || nextpc !== 32'hbfc00054) begin errors++; $display("FAIL bp_front got=%b/%h exp=0/bfc00054", de_allowin, nextpc); end
      @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    checks++; if (de_to_exe_valid !== 1'b0 || de_allowin !== 1'b1) begin errors++; $display("FAIL async_rst_hs got=%b/%b exp=0/1", de_to_exe_valid, de_allowin); end
    checks++; if (de_pc !== RST_PC) begin errors++; $display("FAIL async_rst_pc got=%h exp=%h", de_pc, RST_PC); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reserved();
    apply_reset();
    drive(1'b1, 32'hbfc00060, 32'hfc000000, 1'b1, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    drive(1'b1, 32'hbfc00064, ADDU_I, 1'b1, 1'b0, 32'd0, 32'd0);
    #1;
    checks++; if (de_ri !== 1'b1 || de_op !== 20'd0 || de_dest !== 5'd0) begin errors++; $display("FAIL reserved got=%b/%h/%0d exp=1/00000/0", de_ri, de_op, de_dest); end
    checks++; if (de_to_exe_valid !== 1'b1 || nextpc !== 32'hbfc00068) begin errors++; $display("FAIL reserved_flow got=%b/%h exp=1/bfc00068", de_to_exe_valid, nextpc); end
  endtask

`ifdef DE_FWD_EN
  task automatic test_fwd();
    apply_reset();
    drive(1'b1, 32'hbfc00070, 32'h01095021, 1'b1, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    drive(1'b0, 32'hbfc00074, ADDU_I, 1'b1, 1'b0, 32'hdead, 32'hbeef);
    exe_fwd_we = 1'b1; exe_fwd_dest = 5'd8; exe_fwd_data = 32'h1234;
    mem_fwd_we = 1'b1; mem_fwd_dest = 5'd8; mem_fwd_data = 32'h5555;
    #1;
    checks++; if (de_src1 !== 32'h1234) begin errors++; $display("FAIL fwd_exe got=%h exp=00001234", de_src1); end
    exe_fwd_we = 1'b0;
    #1;
    checks++; if (de_src1 !== 32'h5555) begin errors++; $display("FAIL fwd_mem got=%h exp=00005555", de_src1); end
    mem_fwd_we = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [31:0] fpc;
    logic [31:0] front;
    apply_reset();
    fpc = RST_PC;
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 9) < 8, fpc, rand_inst($urandom_range(0, 20)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) ? 32'($urandom_range(0, 2)) : $urandom,
            32'($urandom_range(0, 2)));
`ifdef DE_FWD_EN
      exe_fwd_we = 1'($urandom); exe_fwd_dest = 5'($urandom_range(0, 3)); exe_fwd_data = $urandom;
      mem_fwd_we = 1'($urandom); mem_fwd_dest = 5'($urandom_range(0, 3)); mem_fwd_data = $urandom;
`endif
      #1;
      model_outputs();
      checks++; if (de_allowin !== e_allowin || de_to_exe_valid !== e_tev) begin errors++; $display("FAIL rnd_hs got=%b/%b exp=%b/%b", de_allowin, de_to_exe_valid, e_allowin, e_tev); end
      checks++; if (nextpc !== e_nextpc) begin errors++; $display("FAIL rnd_nextpc got=%h exp=%h", nextpc, e_nextpc); end
      checks++; if (de_op !== e_op || de_ri !== e_ri) begin errors++; $display("FAIL rnd_op got=%h/%b exp=%h/%b", de_op, de_ri, e_op, e_ri); end
      checks++; if (de_src1 !== e_src1 || de_src2 !== e_src2) begin errors++; $display("FAIL rnd_src got=%h/%h exp=%h/%h", de_src1, de_src2, e_src1, e_src2); end
      checks++; if (de_dest !== e_dest) begin errors++; $display("FAIL rnd_dest got=%0d exp=%0d", de_dest, e_dest); end
      checks++; if (de_rf_raddr1 !== m_inst[25:21] || de_rf_raddr2 !== m_inst[20:16]) begin errors++; $display("FAIL rnd_raddr got=%0d/%0d exp=%0d/%0d", de_rf_raddr1, de_rf_raddr2, m_inst[25:21], m_inst[20:16]); end
      if (de_to_exe_valid && exe_allowin) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_retire got=%h exp=none", de_pc);
        end else begin
          front = exp_q.pop_front();
          if (de_pc !== front) begin errors++; $display("FAIL rnd_retire got=%h exp=%h", de_pc, front); end
        end
      end
      model_step();
      fpc = e_nextpc;
      @(posedge clk);
      #1;
      checks++; if (de_pc !== m_pc || de_inst !== m_inst || de_bd !== m_bd) begin errors++; $display("FAIL rnd_reg got=%h/%h/%b exp=%h/%h/%b", de_pc, de_inst, de_bd, m_pc, m_inst, m_bd); end
      @(negedge clk);
    end
    checks++; if (exp_q.size() > 1) begin errors++; $display("FAIL rnd_leftover got=%0d exp<=1", exp_q.size()); end
  endtask

  initial begin
    drive(1'b0, RST_PC, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0);
    test_reset();
    test_straight_line();
    test_branch(32'hbfc00010, 32'h10220003, 32'd5, 32'hbfc00020, "beq_taken");
    test_branch(32'hbfc00030, 32'h14220003, 32'd7, 32'hbfc00038, "bne_not_taken");
    test_stall_jr();
    test_backpressure_reset();
    test_reserved();
`ifdef DE_FWD_EN
    test_fwd();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
